sigmoid_backward: RTL and testbench



---
 rtl/sigmoid_backward.sv | 85 ++++++++
 tb/tb_sigmoid_backward.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/sigmoid_backward.sv
// sigmoid_backward: dL/dx = dL/dy * s * (1 - s) over a 3-stage valid/ready pipeline.
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   input handshake; in_s (unsigned Q.S_FRAC), in_grad (signed Q.G_FRAC), in_last
//   out_valid/out_ready output handshake; out_grad (signed Q.G_FRAC), out_last
//   busy                any stage holds a valid beat
module sigmoid_backward #(
  parameter int DATA_WIDTH = 16,
  parameter int S_FRAC     = 15,
  parameter int G_FRAC     = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_s,
  input  logic [DATA_WIDTH-1:0] in_grad,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_grad,
  output logic                  out_last,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] ONE = W'(1) << S_FRAC;
  localparam logic [2*W-1:0] HALF = (2*W)'(1) << (S_FRAC - 1);
  localparam logic signed [2*W:0] HALF_S = (2*W+1)'(1) << (S_FRAC - 1);

  if (S_FRAC >= W || G_FRAC >= W) begin : g_param_check
    $error("sigmoid_backward: fractional widths must be below DATA_WIDTH");
  end

  logic en, v1_q, v2_q, v3_q, l1_q, l2_q, l3_q, sat;
  logic [W-1:0] sc_d, om_d, sc_q, om_q, g1_q, d_d, d_q, g2_q, o_d, o_q;
  logic signed [2*W:0] q, r;

  // Whole pipeline advances together; a stalled output freezes every stage.
  assign en        = out_ready | ~v3_q;
  assign in_ready  = en;
  assign out_valid = v3_q;
  assign out_grad  = o_q;
  assign out_last  = l3_q;
  assign busy      = v1_q | v2_q | v3_q;

  always_comb begin
    sc_d = in_s > ONE ? ONE : in_s;
    om_d = ONE - sc_d;
    d_d  = W'(((2*W)'(sc_q) * (2*W)'(om_q) + HALF) >> S_FRAC);
    q    = $signed(g2_q) * $signed({1'b0, d_q});
    r    = (q + HALF_S) >>> S_FRAC;
    // Overflow when the bits above the sign position disagree; unreachable since d <= 0.25.
    sat  = |r[2*W:W-1] & ~&r[2*W:W-1];
    o_d  = !sat ? r[W-1:0] : r[2*W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      v3_q <= 1'b0;
      l1_q <= 1'b0;
      l2_q <= 1'b0;
      l3_q <= 1'b0;
      sc_q <= '0;
      om_q <= '0;
      g1_q <= '0;
      d_q  <= '0;
      g2_q <= '0;
      o_q  <= '0;
    end else if (en) begin
      v1_q <= in_valid;
      sc_q <= sc_d;
      om_q <= om_d;
      g1_q <= in_grad;
      l1_q <= in_last;
      v2_q <= v1_q;
      d_q  <= d_d;
      g2_q <= g1_q;
      l2_q <= l1_q;
      v3_q <= v2_q;
      o_q  <= o_d;
      l3_q <= l2_q;
    end
  end
endmodule

// File: tb/tb_sigmoid_backward.sv
// tb_sigmoid_backward: randomized and directed check of sigmoid_backward against an arithmetic model.
module tb_sigmoid_backward;
  logic clk = 0, rst_n = 0, in_valid = 0, in_last = 0, out_ready = 0;
  logic [15:0] in_s = 0, in_grad = 0;
  logic in_ready, out_valid, out_last, busy;
  logic [15:0] out_grad;

  sigmoid_backward dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_s(in_s), .in_grad(in_grad), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_grad(out_grad),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] g;
    logic        l;
  } beat_t;

  beat_t exp_q[$];
  int errors = 0, checks = 0;
  bit hold = 0, sat_seen = 0;
  logic [15:0] hold_g;
  logic hold_l;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Real-valued rules: s clamped to 1.0, d = round(s*(1-s)), out = floor(g*d + 0.5) in grad units.
  function automatic logic [15:0] model(logic [15:0] s, logic [15:0] g);
    longint sc, d, gs, r;
    sc = (s > 16'h8000) ? 32768 : longint'(s);
    d  = (sc * (32768 - sc) + 16384) / 32768;
    gs = longint'($signed(g));
    r  = gs * d + 16384;
    r  = (r >= 0) ? r / 32768 : -((-r + 32767) / 32768);
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  always @(negedge clk) if (rst_n && dut.v2_q && dut.sat) sat_seen = 1;

  // One clock: drive inputs after the falling edge, then sample and score.
  task automatic step(bit v, logic [15:0] s, logic [15:0] g, bit l, bit rdy);
    beat_t e;
    @(negedge clk);
    in_valid = v; in_s = s; in_grad = g; in_last = l; out_ready = rdy;
    #1;
    if (!rst_n) return;
    if (hold) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_grad", out_grad, hold_g);
      chk("hold_last", out_last, hold_l);
    end
    hold = out_valid && !out_ready;
    hold_g = out_grad;
    hold_l = out_last;
    if (in_valid && in_ready) exp_q.push_back('{model(s, g), l});
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("spurious_out", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("sb_grad", out_grad, e.g);
        chk("sb_last", out_last, e.l);
      end
    end
  endtask

  task automatic idle(int n);
    repeat (n) step(0, 0, 0, 0, 1);
  endtask

  task automatic dir(string tag, logic [15:0] s, logic [15:0] g, logic [15:0] want, bit l);
    step(1, s, g, l, 1);
    chk({tag, "_rdy"}, in_ready, 1);
    idle(2);
    chk({tag, "_early"}, out_valid, 0);
    idle(1);
    chk({tag, "_valid"}, out_valid, 1);
    chk(tag, out_grad, want);
    chk({tag, "_last"}, out_last, l);
    idle(1);
  endtask

  logic [15:0] bs[5] = '{16'h4000, 16'h2000, 16'h1000, 16'h6000, 16'h7000};
  logic [15:0] bg[5] = '{16'h1000, 16'hF000, 16'h0800, 16'h2345, 16'h8000};

  initial begin
    int bi, guard, sent, cyc;
    bit v;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_grad", out_grad, 0);
    chk("rst_out_last", out_last, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;

    dir("one", 16'h4000, 16'h1000, 16'h0400, 1);
    dir("neg", 16'h4000, 16'hF000, 16'hFC00, 0);
    dir("s_zero", 16'h0000, 16'h7FFF, 16'h0000, 1);
    dir("s_one", 16'h8000, 16'h7FFF, 16'h0000, 0);
    dir("s_clamp", 16'hFFFF, 16'h7FFF, 16'h0000, 1);
    dir("rnd_1", 16'h2000, 16'h0001, 16'h0000, 0);
    dir("rnd_3", 16'h2000, 16'h0003, 16'h0001, 0);
    dir("rnd_big", 16'h2000, 16'h1000, 16'h0300, 1);

    bi = 0;
    for (int i = 0; i < 5; i++) begin
      step(1, bs[bi], bg[bi], bi == 4, 0);
      chk("bp_in_ready", in_ready, i < 3);
      if (in_ready) bi++;
    end
    chk("bp_accepted", bi, 3);
    guard = 0;
    while (bi < 5 && guard < 20) begin
      step(1, bs[bi], bg[bi], bi == 4, 1);
      if (in_ready) bi++;
      guard++;
    end
    chk("bp_all_accepted", bi, 5);
    idle(6);
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_busy", busy, 0);

    sent = 0;
    cyc = 0;
    while (sent < 1000 && cyc < 20000) begin
      v = $urandom_range(0, 3) != 0;
      step(v, $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 32768)),
           16'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
      if (v && in_ready) sent++;
      cyc++;
    end
    chk("rnd_sent", sent, 1000);
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 100) begin
      idle(1);
      cyc++;
    end
    idle(1);
    chk("rnd_drained", exp_q.size(), 0);
    chk("rnd_busy", busy, 0);

    step(1, 16'h4000, 16'h1000, 0, 0);
    step(1, 16'h2000, 16'h1000, 1, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    exp_q.delete();
    hold = 0;
    @(negedge clk);
    rst_n = 1;
    dir("post_rst", 16'h2000, 16'h1000, 16'h0300, 1);
    chk("post_rst_empty", exp_q.size(), 0);

    chk("no_saturation", sat_seen, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
